// File: rtl/fft_sample_loader.sv
// fft_sample_loader: packs real samples into complex SRAM words (imag = 0) and
// writes one frame of NUM_WORDS words through the SRAM's single write port.
// Build option BITREV_EN: when defined, frame words are written in bit-reversed
// address order so the FFT engine can read in natural order; when undefined,
// words are written in natural order (bring-up / debug).
//
// state | meaning
// IDLE  | waiting for start; no samples accepted
// LOAD  | accepting samples, one SRAM write per accepted sample
// FULL  | frame complete; holding buffer until frame_release
module fft_sample_loader #(
  parameter int NUM_WORDS    = 131072,
  parameter int WORD_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic                         start,
  input  logic [SAMPLE_WIDTH-1:0]      sample_in,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic                         frame_release,
  output logic                         we,
  output logic [$clog2(NUM_WORDS)-1:0] write_addr,
  output logic [WORD_WIDTH-1:0]        write_data,
  output logic                         busy,
  output logic                         frame_done,
  output logic [15:0]                  frame_count
);

  localparam int AW = $clog2(NUM_WORDS);
  localparam logic [AW-1:0] LAST_CNT = AW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic [AW-1:0] addr_next;

`ifdef BITREV_EN
  // Mirror the sample index so the FFT sees its input in natural order.
  always_comb begin
    addr_next = '0;
    for (int i = 0; i < AW; i++) begin
      addr_next[i] = cnt[AW-1-i];
    end
  end
`else
  // Natural-order addressing for bring-up.
  always_comb begin
    addr_next = cnt;
  end
`endif

  // Handshake and status depend on state alone so upstream never sees a
  // combinational path from sample_valid back to sample_ready.
  always_comb begin
    sample_ready = (state == LOAD);
    busy         = (state != IDLE);
  end

  // Frame sequencer: accepts samples, issues writes one cycle after accept,
  // and holds the buffer once a frame is complete.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state       <= IDLE;
      cnt         <= '0;
      we          <= 1'b0;
      write_addr  <= '0;
      write_data  <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        LOAD: begin
          if (sample_valid) begin
            we         <= 1'b1;
            write_addr <= addr_next;
            write_data <= {{SAMPLE_WIDTH{1'b0}}, sample_in};
            if (cnt == LAST_CNT) begin
              state       <= FULL;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
              cnt         <= '0;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end
        FULL: begin
          // Release wins over a simultaneous start; a fresh start is needed from IDLE.
          if (frame_release) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Scoreboard bench for fft_sample_loader with NUM_WORDS = 8.
module tb_fft_sample_loader;

  localparam int N    = 8;
  localparam int AW   = 3;
  localparam int SW   = 16;
  localparam int WW   = 32;
  localparam int HALF = 5;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          start = 1'b0;
  logic [SW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic          frame_release = 1'b0;
  logic          we;
  logic [AW-1:0] write_addr;
  logic [WW-1:0] write_data;
  logic          busy;
  logic          frame_done;
  logic [15:0]   frame_count;

  fft_sample_loader #(
    .NUM_WORDS(N),
    .WORD_WIDTH(WW),
    .SAMPLE_WIDTH(SW)
  ) dut (
    .clk(clk),
    .rst_l(rst_l),
    .start(start),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .frame_release(frame_release),
    .we(we),
    .write_addr(write_addr),
    .write_data(write_data),
    .busy(busy),
    .frame_done(frame_done),
    .frame_count(frame_count)
  );

  always #HALF clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
    bit          done;
    int          fc;
    longint      t;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // Reference model: 0 = idle, 1 = loading, 2 = full
  int m_state = 0;
  int m_cnt = 0;
  int m_fc = 0;

  function automatic int ref_addr(input int k);
    int r;
    r = k;
`ifdef BITREV_EN
    r = 0;
    for (int i = 0; i < AW; i++)
      if (((k >> i) & 1) != 0) r = r + (1 << (AW - 1 - i));
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One clock of stimulus; the model advances at the edge using the spec rules.
  task automatic step(input logic v, input logic [SW-1:0] s, input logic st, input logic rel);
    exp_t e;
    sample_valid  = v;
    sample_in     = s;
    start         = st;
    frame_release = rel;
    @(posedge clk);
    case (m_state)
      0: if (st) begin m_state = 1; m_cnt = 0; end
      1: if (v) begin
        e.addr = ref_addr(m_cnt);
        e.data = {16'h0000, s};
        e.done = (m_cnt == N - 1);
        e.fc   = (m_cnt == N - 1) ? (m_fc + 1) % 65536 : m_fc;
        e.t    = longint'($time);
        q.push_back(e);
        if (m_cnt == N - 1) begin
          m_fc = (m_fc + 1) % 65536;
          m_state = 2;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      default: if (rel) m_state = 0;
    endcase
    #1;
  endtask

  function automatic logic [SW-1:0] pick_sample(input bit force_vals);
    logic [SW-1:0] s;
    s = SW'($urandom);
    if (force_vals && m_cnt == 5) s = 16'h0005;
    if (force_vals && m_cnt == 6) s = 16'hFFFF;
    return s;
  endfunction

  // Monitor: status every cycle, and each write popped against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    check("sample_ready", 32'(sample_ready), 32'(m_state == 1));
    check("busy", 32'(busy), 32'(m_state != 0));
    if (we) begin
      if (q.size() == 0) begin
        check("unexpected_write", 32'(1), 32'(0));
      end else begin
        e = q.pop_front();
        check("write_latency", 32'(longint'($time) - e.t), 32'(HALF));
        check("write_addr", 32'(write_addr), 32'(e.addr));
        check("write_data", write_data, e.data);
        check("frame_done", 32'(frame_done), 32'(e.done));
        check("frame_count_at_write", 32'(frame_count), 32'(e.fc));
      end
    end else begin
      check("frame_done_without_we", 32'(frame_done), 32'(0));
      if (q.size() > 0 && (longint'($time) - q[0].t) >= HALF) begin
        e = q.pop_front();
        check("missing_write", 32'(0), 32'(1));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int iters;
    int pat[5] = '{1, 0, 0, 1, 1};

    // Reset and idle
    #12;
    rst_l = 1'b1;
    #1;
    check("reset_we", 32'(we), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_ready", 32'(sample_ready), 32'(0));
    check("reset_frame_count", 32'(frame_count), 32'(0));
    check("reset_write_addr", 32'(write_addr), 32'(0));
    check("reset_write_data", write_data, 32'(0));
    for (int i = 0; i < 5; i++) step(1'b1, SW'($urandom), 1'b0, 1'b0);

    // Mid-frame reset after three accepts
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, SW'($urandom), 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst_l = 1'b0;
    m_state = 0;
    m_cnt = 0;
    m_fc = 0;
    #1;
    check("midreset_we", 32'(we), 32'(0));
    check("midreset_busy", 32'(busy), 32'(0));
    check("midreset_frame_count", 32'(frame_count), 32'(m_fc));
    step(1'b0, '0, 1'b0, 1'b0);
    rst_l = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);

    // Frame 1: stall pattern first, then random gaps; fixed values at 5 and 6
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(pat[i][0], pick_sample(1'b1), 1'b0, 1'b0);
    iters = 0;
    while (m_state == 1 && iters < 200) begin
      step(($urandom_range(0, 3) != 0) || iters > 100, pick_sample(1'b1), 1'b0, 1'b0);
      iters++;
    end
    step(1'b0, '0, 1'b0, 1'b0);
    check("frame1_count", 32'(frame_count), 32'(1));
    check("frame1_full_busy", 32'(busy), 32'(1));

    // FULL hold: valid and start are ignored
    for (int i = 0; i < 4; i++) step(1'b1, SW'($urandom), 1'b1, 1'b0);
    check("full_hold_count", 32'(frame_count), 32'(m_fc));
    // Release together with start: release wins, start ignored
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, SW'($urandom), 1'b0, 1'b0);
    check("released_idle_busy", 32'(busy), 32'(0));

    // Frame 2: back-to-back samples with stray start/release noise
    step(1'b0, '0, 1'b1, 1'b0);
    iters = 0;
    while (m_state == 1 && iters < 50) begin
      step(1'b1, pick_sample(1'b0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      iters++;
    end
    step(1'b0, '0, 1'b0, 1'b0);
    check("frame2_count", 32'(frame_count), 32'(2));
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("scoreboard_drained", 32'(q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
